vga_scan: RTL and testbench
===========================

Name: vga_scan

Overview:
- Raster timing generator and pixel sink for the pong display path.
- Produces the scan coordinates x/y that every glyph/paddle/ball renderer consumes as combinational inputs.
- Collects their OR-ed "display" result and turns it into registered 12-bit RGB plus active-low hsync/vsync for the VGA connector.
- Sits between the 100 MHz board clock and all character/object renderers.

Parameters:
- CLK_DIV, 4, board clocks per pixel; must be >= 2.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch, in pixels.
- H_SYNC, 96, hsync pulse width, in pixels.
- H_BACK, 48, horizontal back porch, in pixels.
- V_DISPLAY, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch, in lines.
- V_SYNC, 2, vsync pulse width, in lines.
- V_BACK, 33, vertical back porch, in lines.

Ports:
- clk  in  1  board clock, 100 MHz, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pixel_in  in  1  OR of renderer display outputs for the current x/y.
- color_fg  in  12  RGB444 used when pixel_in=1.
- color_bg  in  12  RGB444 used when pixel_in=0 inside the visible area.
- x  out  10  current horizontal count, 0..H_TOTAL-1.
- y  out  10  current vertical count, 0..V_TOTAL-1.
- video_on  out  1  high when x<H_DISPLAY and y<V_DISPLAY; combinational from counters.
- p_tick  out  1  one-clk pixel strobe.
- frame_start  out  1  one-clk pulse at counter wrap to (0,0).
- hsync  out  1  active-low, registered.
- vsync  out  1  active-low, registered.
- rgb  out  12  registered pixel color.

Behaviour:
- Derived constants:
  - H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800).
  - V_TOTAL = V_DISPLAY+V_FRONT+V_SYNC+V_BACK (525).
- Reset values: div=0, x=0, y=0, hsync=1, vsync=1, rgb=0, p_tick=0, frame_start=0. Reset asserted mid-frame returns everything to these values immediately (asynchronous).
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - p_tick=1 exactly when div==CLK_DIV-1, so the first p_tick falls on the CLK_DIV-th rising edge after reset deasserts.
- Counters advance only on clocks where p_tick=1:
  - x increments and wraps from H_TOTAL-1 to 0.
  - y increments only when x wraps, and wraps from V_TOTAL-1 to 0.
  - Simultaneous wrap of x and y is legal and gives (0,0).
- frame_start = p_tick & (x==H_TOTAL-1) & (y==V_TOTAL-1). It is high for one clk only.
- Output stage, registered on p_tick so it has a one-pixel latency relative to x/y:
  - hsync <= ~(x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]); default window 656..751.
  - vsync <= ~(y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1]); default window 490..491.
  - rgb <= video_on ? (pixel_in ? color_fg : color_bg) : 12'h000.
  - pixel_in, color_fg and color_bg are sampled only on p_tick clocks; changes between ticks are ignored.
- Between p_ticks every register holds its value.
- Widths: x and y are 10 bits. Parameter totals must be <= 1024; the upper bound is not checked in RTL.

Optional Feature:
- Macro: VGA_SCAN_BORDER_EN.
- Defined: pixels with video_on and (x==0 or x==H_DISPLAY-1 or y==0 or y==V_DISPLAY-1) output color_fg regardless of pixel_in. This gives a 1-pixel playfield outline.
- Undefined: no border logic is compiled in, and rgb follows the rule above exactly.

Decomposition:
- Shared package vga_pkg holds:
  - default timing constants, H_TOTAL/V_TOTAL derivation functions;
  - the RGB444 width constant and color typedef;
  - black color constant 12'h000.
- One natural sub-module is vga_pix_div: the divider producing p_tick. It is instantiated once.
- Sync/counter and RGB register logic stays in vga_scan.

Test Plan:
- Reset release -> p_tick first high on clock 4; x=0,y=0, hsync=1, vsync=1, rgb=0 until the first tick; x=1 after the first tick.
- Run one full line -> hsync low for exactly 96 p_ticks, falling after the tick where x=656 (registered); x wraps 799->0 and y increments 0->1 on the same tick.
- Run a full frame -> vsync low for exactly 2 lines (y=490,491 plus a one-pixel lag); frame_start pulses exactly once per 800*525*4 = 1,680,000 clks, at x=799,y=524.
- Color path:
  - pixel_in=1, color_fg=12'hF00 at x=10,y=10 -> rgb=12'hF00 on the next tick.
  - pixel_in=0, color_bg=12'h00F -> rgb=12'h00F.
  - At x=700 with pixel_in=1 -> rgb=12'h000.
- Assert reset mid-line at x=300,y=200, between ticks -> all outputs return to reset values immediately; after release the count restarts at 0,0 with the first tick on clock 4.
- With VGA_SCAN_BORDER_EN defined, pixel_in=0, color_fg=12'h0F0 -> rgb=12'h0F0 at (0,5), (639,5) and (5,479); rgb=color_bg at (1,1). Without the macro -> color_bg at all four points.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, total-count helpers and RGB444 color type.
// Imported by vga_pix_div and vga_scan.
package vga_pkg;

    localparam int RGB_W = 12;
    typedef logic [RGB_W-1:0] rgb_t;
    localparam rgb_t RGB_BLACK = 12'h000;

    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    function automatic int h_total(int d, int f, int s, int b);
        return d + f + s + b;
    endfunction

    function automatic int v_total(int d, int f, int s, int b);
        return d + f + s + b;
    endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel-clock divider: counts 0..CLK_DIV-1, p_tick high on the last count.
// Ports: clk, reset (async, active-high) in; p_tick out.
module vga_pix_div
    import vga_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic p_tick
);

    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] div;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div <= '0;
        else if (div == DIV_LAST)
            div <= '0;
        else
            div <= div + DW'(1);
    end

    assign p_tick = (div == DIV_LAST);

endmodule

// File: rtl/vga_scan.sv
// VGA raster generator: x/y scan counters, sync pulses and registered RGB.
// Ports: clk, reset (async, active-high), pixel_in, color_fg, color_bg in;
//        x, y, video_on, p_tick, frame_start, hsync, vsync, rgb out.
// Optional macro VGA_SCAN_BORDER_EN draws a 1-pixel fg outline.
module vga_scan
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pixel_in,
    input  logic [RGB_W-1:0] color_fg,
    input  logic [RGB_W-1:0] color_bg,
    output logic [9:0]       x,
    output logic [9:0]       y,
    output logic             video_on,
    output logic             p_tick,
    output logic             frame_start,
    output logic             hsync,
    output logic             vsync,
    output logic [RGB_W-1:0] rgb
);

    localparam int H_TOTAL =
        h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL =
        v_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);

    localparam logic [9:0] X_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] Y_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] X_DISP = 10'(H_DISPLAY);
    localparam logic [9:0] Y_DISP = 10'(V_DISPLAY);
    localparam logic [9:0] HS_BEG = 10'(H_DISPLAY + H_FRONT);
    localparam logic [9:0] HS_END = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_DISPLAY + V_FRONT);
    localparam logic [9:0] VS_END = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic x_wrap;
    logic y_wrap;
    logic pix_sel;
    logic hs_win;
    logic vs_win;
    rgb_t rgb_nxt;

    vga_pix_div #(
        .CLK_DIV (CLK_DIV)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .p_tick (p_tick)
    );

    assign x_wrap      = (x == X_LAST);
    assign y_wrap      = (y == Y_LAST);
    assign video_on    = (x < X_DISP) && (y < Y_DISP);
    assign frame_start = p_tick & x_wrap & y_wrap;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (p_tick) begin
            x <= x_wrap ? 10'd0 : x + 10'd1;
            if (x_wrap)
                y <= y_wrap ? 10'd0 : y + 10'd1;
        end
    end

`ifdef VGA_SCAN_BORDER_EN
    // Outline forces the foreground color on the visible-area edge.
    logic border;
    assign border = (x == 10'd0) || (x == X_DISP - 10'd1) ||
                    (y == 10'd0) || (y == Y_DISP - 10'd1);
    assign pix_sel = pixel_in | border;
`else
    assign pix_sel = pixel_in;
`endif

    assign hs_win  = (x >= HS_BEG) && (x <= HS_END);
    assign vs_win  = (y >= VS_BEG) && (y <= VS_END);
    assign rgb_nxt = video_on ? (pix_sel ? color_fg : color_bg)
                              : RGB_BLACK;

    // Output stage lags x/y by one pixel; inputs only sampled on ticks.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hsync <= 1'b1;
            vsync <= 1'b1;
            rgb   <= RGB_BLACK;
        end else if (p_tick) begin
            hsync <= ~hs_win;
            vsync <= ~vs_win;
            rgb   <= rgb_nxt;
        end
    end

endmodule

// File: tb/tb_vga_scan.sv
// Scoreboard bench for vga_scan on a reduced raster.
// Expected sync/rgb pushed on each tick, popped after the edge.
module tb_vga_scan;
    import vga_pkg::*;

    localparam int CLK_DIV = 4;
    localparam int HD = 40;
    localparam int HF = 4;
    localparam int HS = 6;
    localparam int HB = 5;
    localparam int VD = 20;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FRAME_CLKS = HT * VT * CLK_DIV;

`ifdef VGA_SCAN_BORDER_EN
    localparam logic [11:0] EDGE_RGB = 12'h0F0;
`else
    localparam logic [11:0] EDGE_RGB = 12'h123;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        pixel_in;
    logic [11:0] color_fg;
    logic [11:0] color_bg;
    logic [9:0]  x;
    logic [9:0]  y;
    logic        video_on;
    logic        p_tick;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;

    always #5 clk = ~clk;

    vga_scan #(
        .CLK_DIV   (CLK_DIV),
        .H_DISPLAY (HD),
        .H_FRONT   (HF),
        .H_SYNC    (HS),
        .H_BACK    (HB),
        .V_DISPLAY (VD),
        .V_FRONT   (VF),
        .V_SYNC    (VS),
        .V_BACK    (VB)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_in    (pixel_in),
        .color_fg    (color_fg),
        .color_bg    (color_bg),
        .x           (x),
        .y           (y),
        .video_on    (video_on),
        .p_tick      (p_tick),
        .frame_start (frame_start),
        .hsync       (hsync),
        .vsync       (vsync),
        .rgb         (rgb)
    );

    typedef struct {
        int          cx;
        int          cy;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } exp_t;

    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;
    int mdiv;
    int mx;
    int my;
    logic mh;
    logic mv;
    logic [11:0] mrgb;
    int fs_dut = 0;
    int fs_mdl = 0;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_rgb(int cx, int cy, logic pin,
                                            logic [11:0] fg,
                                            logic [11:0] bg);
        logic sel;
        sel = pin;
`ifdef VGA_SCAN_BORDER_EN
        if (cx == 0 || cx == HD-1 || cy == 0 || cy == VD-1)
            sel = 1'b1;
`endif
        if (cx >= HD || cy >= VD)
            return 12'h000;
        return sel ? fg : bg;
    endfunction

    task automatic model_reset();
        mdiv = 0;
        mx   = 0;
        my   = 0;
        mh   = 1'b1;
        mv   = 1'b1;
        mrgb = 12'h000;
        sb.delete();
    endtask

    task automatic check_outs();
        logic tk;
        tk = (mdiv == CLK_DIV-1);
        chk("p_tick", p_tick, tk);
        chk("x", x, mx);
        chk("y", y, my);
        chk("video_on", video_on, (mx < HD) && (my < VD));
        chk("frame_start", frame_start,
            tk && mx == HT-1 && my == VT-1);
        chk("hsync", hsync, mh);
        chk("vsync", vsync, mv);
        chk("rgb", rgb, mrgb);
        if (frame_start === 1'b1)
            fs_dut++;
    endtask

    task automatic step();
        exp_t e;
        logic tk;
        pixel_in = 1'($urandom_range(0, 1));
        color_fg = 12'($urandom);
        color_bg = 12'($urandom);
        if (mx == 10 && my == 10) begin
            pixel_in = 1'b1;
            color_fg = 12'hF00;
        end else if (mx == 12 && my == 10) begin
            pixel_in = 1'b0;
            color_bg = 12'h00F;
        end else if (mx == HD+5 && my == 3) begin
            pixel_in = 1'b1;
            color_fg = 12'hABC;
        end else if ((mx == 0 && my == 5) || (mx == HD-1 && my == 5) ||
                     (mx == 5 && my == VD-1) || (mx == 1 && my == 1)) begin
            pixel_in = 1'b0;
            color_fg = 12'h0F0;
            color_bg = 12'h123;
        end
        tk = (mdiv == CLK_DIV-1);
        if (tk) begin
            e.cx  = mx;
            e.cy  = my;
            e.hs  = !(mx >= HD+HF && mx < HD+HF+HS);
            e.vs  = !(my >= VD+VF && my < VD+VF+VS);
            e.rgb = exp_rgb(mx, my, pixel_in, color_fg, color_bg);
            sb.push_back(e);
            if (mx == HT-1 && my == VT-1)
                fs_mdl++;
            if (mx == HT-1) begin
                mx = 0;
                my = (my == VT-1) ? 0 : my + 1;
            end else begin
                mx = mx + 1;
            end
        end
        mdiv = tk ? 0 : mdiv + 1;
        @(posedge clk);
        #1;
        if (tk) begin
            e    = sb.pop_front();
            mh   = e.hs;
            mv   = e.vs;
            mrgb = e.rgb;
            if (e.cx == 10 && e.cy == 10)
                chk("rgb_fg_10_10", rgb, 12'hF00);
            if (e.cx == 12 && e.cy == 10)
                chk("rgb_bg_12_10", rgb, 12'h00F);
            if (e.cx == HD+5 && e.cy == 3)
                chk("rgb_blank", rgb, 12'h000);
            if (e.cx == 0 && e.cy == 5)
                chk("edge_left", rgb, EDGE_RGB);
            if (e.cx == HD-1 && e.cy == 5)
                chk("edge_right", rgb, EDGE_RGB);
            if (e.cx == 5 && e.cy == VD-1)
                chk("edge_bottom", rgb, EDGE_RGB);
            if (e.cx == 1 && e.cy == 1)
                chk("inner_1_1", rgb, 12'h123);
        end
        check_outs();
    endtask

    initial begin
        bit found;
        reset    = 1'b1;
        pixel_in = 1'b0;
        color_fg = 12'h000;
        color_bg = 12'h000;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outs();
        #2;
        reset = 1'b0;

        repeat (FRAME_CLKS + 100) step();

        found = 1'b0;
        for (int i = 0; i < 2 * FRAME_CLKS; i++) begin
            if (mx == 30 && my == 10 && mdiv == 1) begin
                found = 1'b1;
                break;
            end
            step();
        end
        chk("mid_line_reached", found, 1'b1);

        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_outs();
        #1;
        reset = 1'b0;

        repeat (2 * FRAME_CLKS + 50) step();

        chk("frame_count", fs_dut, fs_mdl);
        chk("frame_count_2", fs_mdl, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
